// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the external memory port arbiter.
// State encoding is fixed so that waveform viewers and debug probes agree across builds.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_I = 2'b01,
        GRANT_D = 2'b10,
        DONE    = 2'b11
    } arb_state_t;

    localparam int DEFAULT_TIMEOUT    = 255;
    localparam int DEFAULT_STARVE_MAX = 2;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    // The bus only ever sees word addresses.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_port_arbiter_bus_timeout_counter.sv
// Counts cycles spent waiting in a grant state and flags when the slave has
// been silent for TIMEOUT cycles. Holds at TIMEOUT until cleared.
module bus_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_count;

    assign expired = (r_count == CNT_W'(TIMEOUT));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the single external memory port shared by instruction
// fetch (I) and the load/store stage (D), with starvation guard and bus timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT    = DEFAULT_TIMEOUT,
    parameter int STARVE_MAX = DEFAULT_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iReq,
    input  logic [ADDR_W-1:0] iAddr,
    output logic [DATA_W-1:0] iData,
    output logic              iAck,
    input  logic              dReq,
    input  logic              dWe,
    input  logic [ADDR_W-1:0] dAddr,
    input  logic [DATA_W-1:0] dWdata,
    input  logic [BE_W-1:0]   dBe,
    output logic [DATA_W-1:0] dData,
    output logic              dAck,
    output logic              busReq,
    output logic              busWe,
    output logic [ADDR_W-1:0] busAddr,
    output logic [DATA_W-1:0] busWdata,
    output logic [BE_W-1:0]   busBe,
    input  logic [DATA_W-1:0] busRdata,
    input  logic              busAck,
    output logic              busErr
);

    localparam int SC_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    arb_state_t        r_state, w_next_state;
    logic [SC_W-1:0]   r_starve_cnt;
    logic              r_busWe, r_iAck, r_dAck, r_busErr;
    logic [ADDR_W-1:0] r_busAddr;
    logic [DATA_W-1:0] r_busWdata, r_iData, r_dData;
    logic [BE_W-1:0]   r_busBe;

    logic w_in_grant, w_expired, w_starved, w_grant_i, w_grant_d;

    assign w_in_grant = (r_state == GRANT_I) || (r_state == GRANT_D);
    assign w_starved  = (r_starve_cnt == SC_W'(STARVE_MAX));
    // D is older in the pipeline and wins ties unless I has waited too long.
    assign w_grant_i  = iReq && (!dReq || w_starved);
    assign w_grant_d  = dReq && !w_grant_i;

    bus_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (r_state == IDLE),
        .enable  (w_in_grant),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: assigning the default before the case keeps every path covered, so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_grant_i)              w_next_state = GRANT_I;
                     else if (w_grant_d)         w_next_state = GRANT_D;
            GRANT_I,
            GRANT_D: if (busAck || w_expired)    w_next_state = DONE;
            DONE:                                w_next_state = IDLE;
            default:                             w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
            r_busWe      <= 1'b0;
            r_busAddr    <= '0;
            r_busWdata   <= '0;
            r_busBe      <= '0;
            r_iData      <= '0;
            r_dData      <= '0;
            r_iAck       <= 1'b0;
            r_dAck       <= 1'b0;
            r_busErr     <= 1'b0;
        end else begin
            r_iAck   <= 1'b0;
            r_dAck   <= 1'b0;
            r_busErr <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_i) begin
                        r_busAddr    <= word_align(iAddr);
                        r_busWe      <= 1'b0;
                        r_busWdata   <= '0;
                        r_busBe      <= '1;
                        r_starve_cnt <= '0;
                    end else if (w_grant_d) begin
                        r_busAddr  <= word_align(dAddr);
                        r_busWe    <= dWe;
                        r_busWdata <= dWe ? dWdata : '0;
                        r_busBe    <= dWe ? dBe : '1;
                        if (!iReq)           r_starve_cnt <= '0;
                        else if (!w_starved) r_starve_cnt <= r_starve_cnt + 1'b1;
                    end
                end
                GRANT_I: begin
                    if (busAck || w_expired) begin
                        r_iData  <= busAck ? busRdata : '0;
                        r_iAck   <= 1'b1;
                        r_busErr <= !busAck;
                    end
                end
                GRANT_D: begin
                    if (busAck || w_expired) begin
                        r_dData  <= (busAck && !r_busWe) ? busRdata : '0;
                        r_dAck   <= 1'b1;
                        r_busErr <= !busAck;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busReq   = w_in_grant;
    assign busWe    = r_busWe;
    assign busAddr  = r_busAddr;
    assign busWdata = r_busWdata;
    assign busBe    = r_busBe;
    assign busErr   = r_busErr;
    assign iData    = r_iData;
    assign iAck     = r_iAck;
    assign dData    = r_dData;
    assign dAck     = r_dAck;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a small wait-state slave model.
// TIMEOUT is shortened to 8 so the abort path is exercised quickly.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        iReq, dReq, dWe;
    logic [31:0] iAddr, dAddr, dWdata;
    logic [3:0]  dBe;
    logic [31:0] iData, dData, busAddr, busWdata, busRdata;
    logic        iAck, dAck, busReq, busWe, busErr, busAck;
    logic [3:0]  busBe;

    int n_tests = 0;
    int n_fail  = 0;

    // Slave model: acks after slave_wait wait states unless dead; force_ack injects stray acks.
    int   slave_wait = 0;
    logic slave_dead = 1'b0;
    logic force_ack  = 1'b0;
    int   wcnt       = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!busReq) wcnt <= 0;
        else         wcnt <= wcnt + 1;
    end

    assign busAck = force_ack || (busReq && !slave_dead && (wcnt == slave_wait));

    mem_port_arbiter #(.TIMEOUT(8), .STARVE_MAX(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .iReq     (iReq),
        .iAddr    (iAddr),
        .iData    (iData),
        .iAck     (iAck),
        .dReq     (dReq),
        .dWe      (dWe),
        .dAddr    (dAddr),
        .dWdata   (dWdata),
        .dBe      (dBe),
        .dData    (dData),
        .dAck     (dAck),
        .busReq   (busReq),
        .busWe    (busWe),
        .busAddr  (busAddr),
        .busWdata (busWdata),
        .busBe    (busBe),
        .busRdata (busRdata),
        .busAck   (busAck),
        .busErr   (busErr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; iReq = 1'b1; iAddr = 32'h0000_1004; busRdata = 32'h2402_0001; slave_wait = 0;
        tick(); tick(); tick();
        n_tests++; if ({busReq, busWe, iAck, dAck, busErr} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {busReq, busWe, iAck, dAck, busErr}); end
        n_tests++; if ({busAddr, busWdata, iData, dData, busBe} !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", {busAddr, busWdata, iData, dData, busBe}); end
        rst = 1'b0;
        tick();
        n_tests++; if ({busReq, busWe, busBe, iAck} !== 7'b1_0_1111_0) begin n_fail++; $display("FAIL reset_grant: got %b want 1011110", {busReq, busWe, busBe, iAck}); end
        n_tests++; if (busAddr !== 32'h0000_1004) begin n_fail++; $display("FAIL reset_addr: got %h want 00001004", busAddr); end
        tick();
        n_tests++; if ({iAck, dAck, busReq} !== 3'b100) begin n_fail++; $display("FAIL reset_ack: got %b want 100", {iAck, dAck, busReq}); end
        n_tests++; if (iData !== 32'h2402_0001) begin n_fail++; $display("FAIL reset_idata: got %h want 24020001", iData); end
        iReq = 1'b0;
        tick();
        n_tests++; if ({iAck, busReq} !== 2'b00) begin n_fail++; $display("FAIL reset_idle: got %b want 00", {iAck, busReq}); end
    endtask

    task automatic test_simultaneous();
        iReq = 1'b1; iAddr = 32'h0000_2000;
        dReq = 1'b1; dWe = 1'b1; dAddr = 32'h0000_3007; dWdata = 32'hAABB_CCDD; dBe = 4'b0011;
        busRdata = 32'h1111_2222;
        tick();
        n_tests++; if ({busReq, busWe, busBe} !== 6'b1_1_0011) begin n_fail++; $display("FAIL sim_d_ctrl: got %b want 110011", {busReq, busWe, busBe}); end
        n_tests++; if (busAddr !== 32'h0000_3004) begin n_fail++; $display("FAIL sim_d_addr: got %h want 00003004", busAddr); end
        n_tests++; if (busWdata !== 32'hAABB_CCDD) begin n_fail++; $display("FAIL sim_d_wdata: got %h want aabbccdd", busWdata); end
        tick();
        n_tests++; if ({dAck, iAck} !== 2'b10) begin n_fail++; $display("FAIL sim_dack: got %b want 10", {dAck, iAck}); end
        n_tests++; if (dData !== 32'h0) begin n_fail++; $display("FAIL sim_store_ddata: got %h want 0", dData); end
        dReq = 1'b0;
        tick();
        n_tests++; if ({busReq, dAck, iAck} !== 3'b000) begin n_fail++; $display("FAIL sim_idle: got %b want 000", {busReq, dAck, iAck}); end
        tick();
        n_tests++; if ({busReq, busWe, busBe} !== 6'b1_0_1111 || busAddr !== 32'h0000_2000) begin n_fail++; $display("FAIL sim_i_grant: got %b/%h want 101111/00002000", {busReq, busWe, busBe}, busAddr); end
        tick();
        n_tests++; if ({iAck, dAck} !== 2'b10 || iData !== 32'h1111_2222) begin n_fail++; $display("FAIL sim_iack: got %b/%h want 10/11112222", {iAck, dAck}, iData); end
        iReq = 1'b0;
        tick();
    endtask

    task automatic test_starvation();
        logic [31:0] exp_addr [6];
        exp_addr = '{32'h4000, 32'h4000, 32'h5000, 32'h4000, 32'h5004, 32'h0};
        iReq = 1'b1; iAddr = 32'h0000_5000;
        dReq = 1'b1; dWe = 1'b0; dAddr = 32'h0000_4000; busRdata = 32'h0BAD_F00D;
        // Each grant takes 3 cycles: grant edge, ack edge, idle edge.
        for (int g = 0; g < 5; g++) begin
            tick();
            n_tests++; if (busReq !== 1'b1 || busAddr !== exp_addr[g]) begin n_fail++; $display("FAIL starve_grant%0d: got req=%b addr=%h want req=1 addr=%h", g, busReq, busAddr, exp_addr[g]); end
            tick();
            if (exp_addr[g][12]) begin
                n_tests++; if ({iAck, dAck} !== 2'b10) begin n_fail++; $display("FAIL starve_ack%0d: got %b want 10", g, {iAck, dAck}); end
                iAddr = 32'h0000_5004;
            end else begin
                n_tests++; if ({iAck, dAck} !== 2'b01 || dData !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL starve_ack%0d: got %b/%h want 01/0badf00d", g, {iAck, dAck}, dData); end
                if (g == 3) dReq = 1'b0;
            end
            tick();
        end
        iReq = 1'b0;
    endtask

    task automatic test_wait_states();
        int acks = 0;
        slave_wait = 5; busRdata = 32'hCAFE_0005;
        dReq = 1'b1; dWe = 1'b0; dAddr = 32'h0000_600A;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (dAck) acks++;
            n_tests++; if (busReq !== 1'b1 || busAddr !== 32'h0000_6008) begin n_fail++; $display("FAIL wait_cycle%0d: got req=%b addr=%h want 1/00006008", c, busReq, busAddr); end
        end
        tick();
        if (dAck) acks++;
        n_tests++; if (busReq !== 1'b0 || dData !== 32'hCAFE_0005) begin n_fail++; $display("FAIL wait_done: got req=%b data=%h want 0/cafe0005", busReq, dData); end
        tick();
        if (dAck) acks++;
        dReq = 1'b0;
        tick();
        if (dAck) acks++;
        n_tests++; if (busReq !== 1'b0) begin n_fail++; $display("FAIL wait_no_regrant: got %b want 0", busReq); end
        n_tests++; if (acks !== 1) begin n_fail++; $display("FAIL wait_ack_count: got %0d want 1", acks); end
        slave_wait = 0;
    endtask

    task automatic test_timeout();
        slave_dead = 1'b1;
        dReq = 1'b1; dWe = 1'b0; dAddr = 32'h0000_7000;
        tick();
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_tests++; if ({busReq, busErr, dAck} !== 3'b100) begin n_fail++; $display("FAIL tmo_wait%0d: got %b want 100", k, {busReq, busErr, dAck}); end
        end
        tick();
        n_tests++; if ({busReq, busErr, dAck} !== 3'b011) begin n_fail++; $display("FAIL tmo_abort: got %b want 011", {busReq, busErr, dAck}); end
        n_tests++; if (dData !== 32'h0) begin n_fail++; $display("FAIL tmo_ddata: got %h want 0", dData); end
        dReq = 1'b0;
        tick();
        n_tests++; if ({busErr, dAck} !== 2'b00) begin n_fail++; $display("FAIL tmo_pulse_end: got %b want 00", {busErr, dAck}); end
        slave_dead = 1'b0; busRdata = 32'h3333_4444;
        iReq = 1'b1; iAddr = 32'h0000_0100;
        tick(); tick();
        n_tests++; if ({iAck, busErr} !== 2'b10 || iData !== 32'h3333_4444) begin n_fail++; $display("FAIL tmo_recover: got %b/%h want 10/33334444", {iAck, busErr}, iData); end
        iReq = 1'b0;
        tick();
    endtask

    task automatic test_mid_reset();
        slave_wait = 5;
        dReq = 1'b1; dWe = 1'b1; dAddr = 32'h0000_8000; dWdata = 32'h1234_5678; dBe = 4'hF;
        tick(); tick(); tick();
        n_tests++; if (busReq !== 1'b1) begin n_fail++; $display("FAIL midrst_active: got %b want 1", busReq); end
        rst = 1'b1; dReq = 1'b0;
        tick();
        n_tests++; if ({busReq, busWe, dAck} !== 3'b000 || busAddr !== 32'h0) begin n_fail++; $display("FAIL midrst_idle: got %b/%h want 000/0", {busReq, busWe, dAck}, busAddr); end
        rst = 1'b0; force_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++; if ({busReq, dAck, iAck, busErr} !== 4'b0) begin n_fail++; $display("FAIL midrst_late_ack%0d: got %b want 0000", k, {busReq, dAck, iAck, busErr}); end
        end
        force_ack = 1'b0; slave_wait = 0;
    endtask

    initial begin
        rst = 1'b1; iReq = 1'b0; dReq = 1'b0; dWe = 1'b0;
        iAddr = '0; dAddr = '0; dWdata = '0; dBe = '0; busRdata = '0;
        #1;
        test_reset();
        test_simultaneous();
        test_starvation();
        test_wait_states();
        test_timeout();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary within the time limit");
        $fatal(1);
    end

endmodule
